// File: rtl/pulse_train_gen.sv
// rtl/pulse_train_gen.sv - programmable high/low pulse-train generator with valid/ready request and done strobe
module pulse_train_gen #(
    parameter int LEN_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [LEN_W-1:0] high_len_i,
    input  logic [LEN_W-1:0] low_len_i,
    input  logic [NUM_W-1:0] num_pulses_i,
    input  logic             abort_i,
    output logic             wave_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [LEN_W-1:0] high_q, high_d;
    logic [LEN_W-1:0] low_q, low_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [NUM_W-1:0] rem_q, rem_d;
    logic             wave_q, wave_d;
    logic             aborted_q, aborted_d;

    always_comb begin
        state_d   = state_q;
        high_d    = high_q;
        low_d     = low_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        aborted_d = aborted_q;
        case (state_q)
            S_IDLE: begin
                aborted_d = 1'b0;
                if (req_valid_i) begin
                    high_d = high_len_i;
                    // A zero low phase would merge pulses, so it is stretched to one cycle.
                    low_d  = (low_len_i == '0) ? LEN_ONE : low_len_i;
                    rem_d  = num_pulses_i;
                    cnt_d  = high_len_i;
                    if (num_pulses_i == '0 || high_len_i == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HIGH;
                    end
                end
            end
            S_HIGH: begin
                if (abort_i) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (cnt_q == LEN_ONE) begin
                    state_d = S_LOW;
                    cnt_d   = low_q;
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            S_LOW: begin
                // Abort wins even on the natural final cycle so the requester sees it.
                if (abort_i) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (cnt_q == LEN_ONE) begin
                    rem_d = rem_q - NUM_ONE;
                    if (rem_q == NUM_ONE) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HIGH;
                        cnt_d   = high_q;
                    end
                end else begin
                    cnt_d = cnt_q - LEN_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        wave_d = (state_d == S_HIGH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            high_q    <= '0;
            low_q     <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            wave_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            high_q    <= high_d;
            low_q     <= low_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            wave_q    <= wave_d;
            aborted_q <= aborted_d;
        end
    end

    assign wave_o      = wave_q;
    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign aborted_o   = aborted_q && (state_q == S_DONE);

endmodule

// File: tb/tb_pulse_train_gen.sv
// tb/tb_pulse_train_gen.sv - randomized and directed checks of pulse_train_gen against a cycle-index model
module tb_pulse_train_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [7:0] high_len_i = '0;
    logic [7:0] low_len_i = '0;
    logic [7:0] num_pulses_i = '0;
    logic       abort_i = 1'b0;
    logic       wave_o, busy_o, done_o, aborted_o;

    logic       w_valid = 1'b0;
    logic       w_ready;
    logic [3:0] w_high = '0;
    logic [3:0] w_low = '0;
    logic [7:0] w_num = '0;
    logic       w_abort = 1'b0;
    logic       w_wave, w_busy, w_done, w_aborted;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pulse_train_gen #(.LEN_W(8), .NUM_W(8)) dut (
        .clk(clk), .reset(reset), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .high_len_i(high_len_i), .low_len_i(low_len_i), .num_pulses_i(num_pulses_i),
        .abort_i(abort_i), .wave_o(wave_o), .busy_o(busy_o), .done_o(done_o),
        .aborted_o(aborted_o)
    );

    pulse_train_gen #(.LEN_W(4), .NUM_W(8)) dut4 (
        .clk(clk), .reset(reset), .req_valid_i(w_valid), .req_ready_o(w_ready),
        .high_len_i(w_high), .low_len_i(w_low), .num_pulses_i(w_num),
        .abort_i(w_abort), .wave_o(w_wave), .busy_o(w_busy), .done_o(w_done),
        .aborted_o(w_aborted)
    );

    // Cycle index (1-based after acceptance) of the natural done strobe.
    function automatic int nat_done(input int h, input int l, input int n);
        if (h == 0 || n == 0) return 1;
        return n * (h + ((l == 0) ? 1 : l)) + 1;
    endfunction

    function automatic logic exp_wave(input int k, input int h, input int l, input int n);
        int p;
        if (h == 0 || n == 0) return 1'b0;
        p = h + ((l == 0) ? 1 : l);
        if (k < 1 || k > n * p) return 1'b0;
        return ((k - 1) % p) < h;
    endfunction

    // a = cycle in which abort_i is held high, 0 for none.
    task automatic run_train(input int h, input int l, input int n, input int a);
        int nd, endc, rises, falls, pulses;
        logic ab, prev;
        logic [4:0] obs, expv;
        nd   = nat_done(h, l, n);
        ab   = (a >= 1) && (a <= nd - 1);
        endc = ab ? a + 1 : nd;
        @(negedge clk);
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL ready_before_req h=%0d l=%0d n=%0d got=%b want=1", h, l, n, req_ready_o);
        end
        req_valid_i  = 1'b1;
        high_len_i   = h[7:0];
        low_len_i    = l[7:0];
        num_pulses_i = n[7:0];
        @(posedge clk);
        #1;
        req_valid_i  = 1'b0;
        high_len_i   = 8'($urandom);
        low_len_i    = 8'($urandom);
        num_pulses_i = 8'($urandom);
        prev = 1'b0; rises = 0; falls = 0;
        for (int k = 1; k <= endc + 1; k++) begin
            @(negedge clk);
            obs  = {wave_o, done_o, aborted_o, busy_o, req_ready_o};
            expv = {(k < endc) && exp_wave(k, h, l, n), k == endc, (k == endc) && ab,
                    k <= endc, k > endc};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL train h=%0d l=%0d n=%0d a=%0d cycle=%0d wave/done/abrt/busy/rdy got=%b want=%b",
                         h, l, n, a, k, obs, expv);
            end
            if (wave_o && !prev) rises++;
            if (!wave_o && prev) falls++;
            prev = wave_o;
            abort_i = (k == a);
        end
        abort_i = 1'b0;
        if (!ab) begin
            pulses = (h == 0 || n == 0) ? 0 : n;
            total++;
            if (rises != pulses || falls != pulses) begin
                bad++;
                $display("FAIL edge_count h=%0d l=%0d n=%0d got rise=%0d fall=%0d want=%0d",
                         h, l, n, rises, falls, pulses);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({wave_o, done_o, aborted_o, busy_o, req_ready_o} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_state got=%b want=00001", {wave_o, done_o, aborted_o, busy_o, req_ready_o});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_train(2, 3, 2, 0);
    endtask

    task automatic test_degenerate();
        run_train(5, 4, 0, 0);
        run_train(0, 2, 3, 0);
        run_train(1, 0, 3, 0);
    endtask

    task automatic test_abort();
        run_train(4, 4, 10, 6);
        run_train(2, 3, 2, 10);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            abort_i = 1'b1;
            total++;
            if ({done_o, aborted_o, busy_o, req_ready_o} !== 4'b0001) begin
                bad++;
                $display("FAIL abort_in_idle got=%b want=0001", {done_o, aborted_o, busy_o, req_ready_o});
            end
        end
        abort_i = 1'b0;
    endtask

    task automatic test_random();
        int h, l, n, a;
        for (int t = 0; t < 14; t++) begin
            h = $urandom_range(0, 5);
            l = $urandom_range(0, 5);
            n = $urandom_range(0, 4);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, nat_done(h, l, n) + 1) : 0;
            run_train(h, l, n, a);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] obs, expv;
        @(negedge clk);
        req_valid_i = 1'b1; high_len_i = 8'd1; low_len_i = 8'd1; num_pulses_i = 8'd1;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            obs  = {wave_o, req_ready_o};
            expv = {((k - 1) % 4) == 0, (k % 4) == 0};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL back_to_back cycle=%0d wave/rdy got=%b want=%b", k, obs, expv);
            end
            if (k % 4 == 1) begin
                high_len_i = 8'd7; num_pulses_i = 8'd5;
            end else if (k % 4 == 3) begin
                high_len_i = 8'd1; num_pulses_i = 8'd1;
            end
            if (k == 16) req_valid_i = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid_i = 1'b1; high_len_i = 8'd3; low_len_i = 8'd2; num_pulses_i = 8'd3;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (wave_o !== 1'b1) begin
            bad++;
            $display("FAIL pulse2_high got=%b want=1", wave_o);
        end
        reset = 1'b1;
        #1;
        total++;
        if ({wave_o, done_o, aborted_o, busy_o, req_ready_o} !== 5'b00001) begin
            bad++;
            $display("FAIL reset_mid got=%b want=00001", {wave_o, done_o, aborted_o, busy_o, req_ready_o});
        end
        @(negedge clk);
        reset = 1'b0;
        run_train(3, 2, 1, 0);
    endtask

    task automatic test_width_limits();
        logic [4:0] obs, expv;
        @(negedge clk);
        w_valid = 1'b1; w_high = 4'd15; w_low = 4'd15; w_num = 8'd2;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        for (int k = 1; k <= 62; k++) begin
            @(negedge clk);
            obs  = {w_wave, w_done, w_aborted, w_busy, w_ready};
            expv = {exp_wave(k, 15, 15, 2), k == 61, 1'b0, k <= 61, k > 61};
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL width_limit cycle=%0d got=%b want=%b", k, obs, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_degenerate();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_width_limits();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Programmable pulse-train generator. It drives a single registered, glitch-free serial line `wave_o` with a requested number of high/low pulses. It is the driving end of the serial lines that our edge-detection logic samples, and it serves as both the stimulus source for edge-detector benches and as an on-chip strobe source. Requests arrive over a valid/ready handshake, and completion is reported with a one-cycle `done_o` strobe.

## Interface
- `LEN_W`, default 8: width of the high/low length fields, in clock cycles.
- `NUM_W`, default 8: width of the pulse-count field.

- `clk`  in  1  clock; all logic on posedge.
- `reset`  in  1  asynchronous, active-high.
- `req_valid_i`  in  1  request present.
- `req_ready_o`  out  1  block can accept a request; 1 only in IDLE.
- `high_len_i`  in  LEN_W  high-phase length per pulse, in cycles.
- `low_len_i`  in  LEN_W  low-phase length per pulse, in cycles.
- `num_pulses_i`  in  NUM_W  number of pulses to emit.
- `abort_i`  in  1  synchronous abort of the current train.
- `wave_o`  out  1  generated serial line; registered.
- `busy_o`  out  1  state is not IDLE.
- `done_o`  out  1  one-cycle completion strobe.
- `aborted_o`  out  1  valid with `done_o`: 1 when the train ended by abort.

## Operation
- States: IDLE, HIGH, LOW, DONE. All outputs are decoded from registered state and counters, so there are no combinational paths from inputs to outputs.
- **IDLE:**
  - `req_ready_o` = 1.
  - On `req_valid_i` & `req_ready_o`, latch H = `high_len_i`, L = max(`low_len_i`, 1), N = `num_pulses_i`.
  - Input changes after acceptance are ignored.
  - If N = 0 or H = 0, go to DONE; no edges are emitted. Otherwise go to HIGH.
- **HIGH:**
  - `wave_o` = 1 for exactly H cycles.
  - Then go to LOW.
- **LOW:**
  - `wave_o` = 0 for exactly L cycles.
  - At the end of the L-th cycle, decrement the remaining count. If the count is still nonzero, go to HIGH; otherwise go to DONE.
- **DONE:**
  - `wave_o` = 0, `done_o` = 1 for exactly one cycle.
  - Then go to IDLE.
- `low_len_i` = 0 is forced to 1. This guarantees every pulse produces one rising and one falling edge.
- `abort_i` sampled high in HIGH or LOW:
  - next cycle: state DONE, `wave_o` = 0, `done_o` = 1, `aborted_o` = 1.
  - `abort_i` is ignored in IDLE and DONE.
  - `abort_i` coinciding with the natural last LOW cycle still reports `aborted_o` = 1.
- `aborted_o` = 0 whenever `done_o` = 0. It is also 0 for normal and degenerate completions.
- Counters are LEN_W / NUM_W wide and count down. Maximum lengths (2^LEN_W − 1) must work with no wrap-around.

## Timing
- Reset (asynchronous, immediate):
  - state IDLE; `wave_o` = 0, `busy_o` = 0, `done_o` = 0, `aborted_o` = 0, `req_ready_o` = 1.
  - Reset in the middle of a train kills it with no `done_o`.
- Acceptance at clock edge E0. Cycle k means the k-th cycle after E0:
  - `wave_o` = 1 in cycles 1..H and 0 in cycles H+1..H+L.
  - Pulse p (0-based) rises at cycle p·(H+L)+1.
  - `done_o` is asserted in cycle N·(H+L)+1.
  - `req_ready_o` = 1 again in cycle N·(H+L)+2.
- Degenerate request (N = 0 or H = 0): `done_o` in cycle 1, `req_ready_o` in cycle 2.
- `busy_o` = 1 from cycle 1 through the `done_o` cycle inclusive.
- The earliest back-to-back request is accepted at the edge ending the first `req_ready_o` cycle. This gives a minimum gap of 2 low cycles (DONE + IDLE) between trains.
- Abort sampled at edge Ea: `wave_o` = 0 and `done_o` = 1 in the cycle after Ea.

## Test plan
- **Basic train:** H=2, L=3, N=2, accepted at E0.
  - `wave_o` = 1,1,0,0,0,1,1,0,0,0 over cycles 1..10.
  - `done_o` = 1 at cycle 11, `aborted_o` = 0, `req_ready_o` = 1 at cycle 12.
  - A companion edge detector counts exactly 2 rising and 2 falling edges.
- **Degenerate and forced-length cases:**
  - N=0, H=5: no `wave_o` activity; `done_o` at cycle 1.
  - H=0, N=3: same result.
  - L=0, H=1, N=3: `wave_o` = 1,0,1,0,1,0; `done_o` at cycle 7.
- **Abort:** H=4, L=4, N=10; `abort_i` pulsed at cycle 6.
  - `wave_o` = 0 and `done_o` = `aborted_o` = 1 at cycle 7.
  - IDLE at cycle 8.
  - `abort_i` held in IDLE has no effect.
- **Back-to-back:** `req_valid_i` held high with fixed fields H=1, L=1, N=1.
  - Accepts every 4 cycles.
  - `wave_o` pattern is 1,0,0,0 repeating.
  - `req_valid_i` is ignored while `busy_o` = 1, and fields changed mid-train do not alter the train.
- **Reset mid-operation:** `reset` asserted during HIGH of pulse 2.
  - `wave_o` = 0 immediately, with no `done_o`.
  - After release: `req_ready_o` = 1 and a new H=3, L=2, N=1 train runs correctly.
- **Width limits:** LEN_W=4, H=15, L=15, N=2.
  - 15-cycle high and low phases with no wrap-around.
  - `done_o` at cycle 61.
